// File: rtl/interrupt_arbiter.sv
// Round-robin merge of NUM_SRC edge-triggered interrupt lines onto cp0's single
// interrupt input, holding the request through the TakenInterrupt/ERET handshake.
module interrupt_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_data,
  input  logic               ack_wr,
  input  logic [2:0]         ack_id,
  input  logic               taken,
  input  logic               eret,
  output logic               irq_out,
  output logic [2:0]         irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               in_service
);

  // state   | meaning
  // IDLE    | no request outstanding; arbitrate among eligible sources
  // REQ     | irq_out asserted for irq_id, waiting for cp0 to take it
  // SERVICE | handler running; irq_out mirrors the live pending bit
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] ack_hot;
  logic [NUM_SRC-1:0] id_hot;
  logic [NUM_SRC-1:0] pending_next;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] eligible_next;
  logic               granted_pend_next;
  logic               granted_elig_next;
  logic [2:0]         rr_ptr;
  logic [2:0]         rr_after;
  logic [2:0]         grant_id;
  logic [3:0]         rr_idx;
  logic               grant_valid;

  always_comb begin
    ack_hot = '0;
    id_hot  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_hot[i] = ack_wr && (ack_id == 3'(i));
      id_hot[i]  = (irq_id == 3'(i));
    end
  end

  // A rising edge outranks a same-cycle ack of the same bit.
  assign rise              = irq_in & ~irq_prev;
  assign pending_next      = (pending & ~ack_hot) | rise;
  assign eligible          = pending & mask;
  assign eligible_next     = pending_next & (mask_wr ? mask_data : mask);
  assign granted_pend_next = |(pending_next & id_hot);
  assign granted_elig_next = |(eligible_next & id_hot);
  assign rr_after          = (irq_id == 3'(NUM_SRC - 1)) ? 3'd0 : irq_id + 3'd1;

  // Search rr_ptr, rr_ptr+1, ... wrapping at NUM_SRC; first eligible wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    rr_idx      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rr_idx = 4'(rr_ptr) + 4'(k);
      if (rr_idx >= 4'(NUM_SRC)) rr_idx = rr_idx - 4'(NUM_SRC);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!grant_valid && eligible[i] && (rr_idx == 4'(i))) begin
          grant_valid = 1'b1;
          grant_id    = 3'(i);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_prev <= '0;
      pending  <= '0;
      mask     <= '0;
    end else begin
      irq_prev <= irq_in;
      pending  <= pending_next;
      if (mask_wr) mask <= mask_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      irq_out    <= 1'b0;
      irq_id     <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            irq_id  <= grant_id;
            irq_out <= 1'b1;
            state   <= REQ;
          end else begin
            irq_out <= 1'b0;
          end
        end
        REQ: begin
          if (taken) begin
            state      <= SERVICE;
            in_service <= 1'b1;
            irq_out    <= granted_pend_next;
          end else if (!granted_elig_next) begin
            state   <= IDLE;
            irq_out <= 1'b0;
          end
        end
        SERVICE: begin
          if (eret) begin
            state      <= IDLE;
            in_service <= 1'b0;
            irq_out    <= 1'b0;
            rr_ptr     <= rr_after;
          end else begin
            irq_out <= granted_pend_next;
          end
        end
        default: begin
          state      <= IDLE;
          in_service <= 1'b0;
          irq_out    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: stimulus queues timestamped expectations
// and expected grant ids; negedge monitors pop and compare.
module tb_interrupt_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_wr;
  logic [3:0] mask_data;
  logic       ack_wr;
  logic [2:0] ack_id;
  logic       taken;
  logic       eret;
  logic       irq_out;
  logic [2:0] irq_id;
  logic [3:0] pending;
  logic       in_service;

  interrupt_arbiter #(.NUM_SRC(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .ack_wr     (ack_wr),
    .ack_id     (ack_id),
    .taken      (taken),
    .eret       (eret),
    .irq_out    (irq_out),
    .irq_id     (irq_id),
    .pending    (pending),
    .in_service (in_service)
  );

  typedef struct {
    string      nm;
    int         cyc;
    logic       o;
    logic [2:0] id;
    logic [3:0] p;
    logic       s;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mi;
  logic prev_out = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  // State monitor: compares every expectation that falls due this cycle.
  always @(negedge clock) begin
    mi = 0;
    while (mi < exp_q.size()) begin
      if (exp_q[mi].cyc <= cyc) begin
        checks = checks + 1;
        if (exp_q[mi].cyc < cyc || irq_out !== exp_q[mi].o || in_service !== exp_q[mi].s ||
            pending !== exp_q[mi].p || ((exp_q[mi].o || exp_q[mi].s) && irq_id !== exp_q[mi].id)) begin
          errors = errors + 1;
          $display("FAIL %s cyc=%0d got irq_out=%b irq_id=%0d pending=%b in_service=%b want irq_out=%b irq_id=%0d pending=%b in_service=%b",
                   exp_q[mi].nm, cyc, irq_out, irq_id, pending, in_service,
                   exp_q[mi].o, exp_q[mi].id, exp_q[mi].p, exp_q[mi].s);
        end
        exp_q.delete(mi);
      end else begin
        mi = mi + 1;
      end
    end
  end

  // Grant monitor: each new request to cp0 must carry the next expected id.
  always @(negedge clock) begin
    if (irq_out === 1'b1 && prev_out === 1'b0) begin
      checks = checks + 1;
      if (grant_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL grant_unexpected cyc=%0d got irq_id=%0d want no grant", cyc, irq_id);
      end else begin
        if (int'(irq_id) != grant_q[0]) begin
          errors = errors + 1;
          $display("FAIL grant_id cyc=%0d got irq_id=%0d want %0d", cyc, irq_id, grant_q[0]);
        end
        void'(grant_q.pop_front());
      end
    end
    prev_out = irq_out;
  end

  task automatic want(input string nm, input int d, input logic o, input logic [2:0] id,
                      input logic [3:0] p, input logic s);
    exp_t e;
    e.nm = nm; e.cyc = cyc + d; e.o = o; e.id = id; e.p = p; e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; irq_in = '0; mask_wr = 1'b0; mask_data = '0;
    ack_wr = 1'b0; ack_id = '0; taken = 1'b0; eret = 1'b0;
    want("reset_state", 1, 1'b0, 3'd0, 4'b0000, 1'b0);
    step(); step();
    reset = 1'b1;
    step();

    // 1: single source, two-edge latency to irq_out
    mask_wr = 1'b1; mask_data = 4'b1111; step();
    mask_wr = 1'b0; irq_in = 4'b0100;
    want("t1_pending", 1, 1'b0, 3'd0, 4'b0100, 1'b0);
    want("t1_request", 2, 1'b1, 3'd2, 4'b0100, 1'b0);
    grant_q.push_back(2);
    step();
    irq_in = '0; step();

    // 2: handshake, ack drops irq_out, eret returns to IDLE
    taken = 1'b1; want("t2_service", 1, 1'b1, 3'd2, 4'b0100, 1'b1); step();
    taken = 1'b0; ack_wr = 1'b1; ack_id = 3'd2;
    want("t2_ack", 1, 1'b0, 3'd2, 4'b0000, 1'b1); step();
    ack_wr = 1'b0; eret = 1'b1;
    want("t2_eret", 1, 1'b0, 3'd0, 4'b0000, 1'b0); step();
    eret = 1'b0;

    // 3: tie between 0 and 3 with rr_ptr=3, then wrap to 0
    irq_in = 4'b1001;
    want("t3_pending", 1, 1'b0, 3'd0, 4'b1001, 1'b0);
    want("t3_grant3", 2, 1'b1, 3'd3, 4'b1001, 1'b0);
    grant_q.push_back(3);
    step();
    irq_in = '0; step();
    taken = 1'b1; step();
    taken = 1'b0; ack_wr = 1'b1; ack_id = 3'd3; step();
    ack_wr = 1'b0; eret = 1'b1;
    want("t3_eret", 1, 1'b0, 3'd0, 4'b0001, 1'b0); step();
    eret = 1'b0;
    want("t3_grant0", 1, 1'b1, 3'd0, 4'b0001, 1'b0);
    grant_q.push_back(0);
    step();
    taken = 1'b1; step();
    taken = 1'b0; ack_wr = 1'b1; ack_id = 3'd0; step();
    ack_wr = 1'b0; eret = 1'b1; step();
    eret = 1'b0;
    want("t3_idle", 1, 1'b0, 3'd0, 4'b0000, 1'b0);
    step();

    // 4: masked source latches but does not request until unmasked
    mask_wr = 1'b1; mask_data = 4'b0000; step();
    mask_wr = 1'b0; irq_in = 4'b0010;
    want("t4_latched", 1, 1'b0, 3'd0, 4'b0010, 1'b0);
    want("t4_masked", 3, 1'b0, 3'd0, 4'b0010, 1'b0);
    step();
    irq_in = '0; step(); step();
    mask_wr = 1'b1; mask_data = 4'b0010;
    want("t4_mask_lands", 1, 1'b0, 3'd0, 4'b0010, 1'b0);
    want("t4_unmasked", 2, 1'b1, 3'd1, 4'b0010, 1'b0);
    grant_q.push_back(1);
    step();
    mask_wr = 1'b0; step();

    // 5: withdrawal by ack, rise+ack collision, ignored acks, withdrawal by mask
    ack_wr = 1'b1; ack_id = 3'd1;
    want("t5_withdraw_ack", 1, 1'b0, 3'd0, 4'b0000, 1'b0); step();
    irq_in = 4'b0010;
    want("t5_rise_beats_ack", 1, 1'b0, 3'd0, 4'b0010, 1'b0); step();
    ack_wr = 1'b0; irq_in = '0;
    want("t5_regrant", 1, 1'b1, 3'd1, 4'b0010, 1'b0);
    grant_q.push_back(1);
    step();
    ack_wr = 1'b1; ack_id = 3'd5;
    want("t5_ack_out_of_range", 1, 1'b1, 3'd1, 4'b0010, 1'b0); step();
    ack_id = 3'd3;
    want("t5_ack_not_pending", 1, 1'b1, 3'd1, 4'b0010, 1'b0); step();
    ack_wr = 1'b0; mask_wr = 1'b1; mask_data = 4'b0000;
    want("t5_withdraw_mask", 1, 1'b0, 3'd0, 4'b0010, 1'b0); step();
    mask_data = 4'b0010; step();
    mask_wr = 1'b0;
    want("t5_regrant_mask", 1, 1'b1, 3'd1, 4'b0010, 1'b0);
    grant_q.push_back(1);
    step();
    taken = 1'b1; ack_wr = 1'b1; ack_id = 3'd1;
    want("t5_taken_over_withdraw", 1, 1'b0, 3'd1, 4'b0000, 1'b1); step();
    taken = 1'b0; ack_wr = 1'b0; irq_in = 4'b0001;
    want("t5_service_hold", 1, 1'b0, 3'd1, 4'b0001, 1'b1); step();
    irq_in = '0; step();

    // 6: asynchronous reset mid-service, then mask confirmed cleared
    @(posedge clock); #2;
    reset = 1'b0;
    want("t6_async_reset", 0, 1'b0, 3'd0, 4'b0000, 1'b0);
    step(); step();
    reset = 1'b1; step();
    irq_in = 4'b0010;
    want("t6_pend_after_reset", 1, 1'b0, 3'd0, 4'b0010, 1'b0);
    want("t6_mask_cleared", 2, 1'b0, 3'd0, 4'b0010, 1'b0);
    step();
    irq_in = '0; step(); step(); step();

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL exp_queue_drain got %0d left want 0", exp_q.size());
    end
    checks = checks + 1;
    if (grant_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL grant_queue_drain got %0d left want 0", grant_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got no finish want finish before 20000");
    $fatal(1);
  end

endmodule
